// File: rtl/conv_mdc_package.sv
// Shared types for the MDC stream controller: FSM states and control/flag bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_mdc_package;

  // Default channel configuration, used to size the register-map style bundles below.
  localparam int unsigned MDC_N_IN  = 2;
  localparam int unsigned MDC_N_OUT = 2;
  localparam int unsigned MDC_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Job request as seen by a controlling register file.
  typedef struct packed {
    logic                                   start;
    logic [MDC_N_IN-1:0][MDC_CNT_W-1:0]     len_in;
    logic [MDC_N_OUT-1:0][MDC_CNT_W-1:0]    len_out;
  } ctrl_mdc_stream_t;

  // Status as seen by a controlling register file; input channels in the LSBs.
  typedef struct packed {
    logic                                   busy;
    logic                                   done;
    logic [MDC_N_IN+MDC_N_OUT-1:0]          ch_done;
  } flags_mdc_stream_t;

endpackage

// File: rtl/conv_mdc_stream_gate.sv
// One stream channel gate: passes valid/ready while open, counts beats against a latched length.
// Latency: zero (combinational valid/ready/data path); done flag registered one cycle after the last beat.
// Backpressure: downstream ready is forwarded upstream while open; once the length is reached both sides are held at 0.
module conv_mdc_stream_gate
  import conv_mdc_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  run_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic                  up_valid_i,
  input  logic [DATA_WIDTH-1:0] up_data_i,
  output logic                  up_ready_o,
  output logic                  dn_valid_o,
  output logic [DATA_WIDTH-1:0] dn_data_o,
  input  logic                  dn_ready_i,
  output logic                  done_o,
  output logic                  done_nxt_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 done_q, done_d;
  logic                 open;
  logic                 fire;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Handshake gating; the cnt!=len term keeps a zero-length channel shut in its first RUN cycle.
  always_comb begin
    open       = run_i & ~done_q & (cnt_q != len_q);
    dn_valid_o = up_valid_i & open;
    up_ready_o = dn_ready_i & open;
    dn_data_o  = up_data_i;
    fire       = up_valid_i & dn_ready_i & open;
    cnt_inc    = cnt_q + CNT_WIDTH'(fire);
    done_nxt_o = done_q | (cnt_inc == len_q);
  end

  // Next-state for counter, length and done flag; clear wins over load, which wins over counting.
  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    done_d = done_q;
    if (clear_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (load_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
      len_d  = len_i;
    end else if (run_i) begin
      cnt_d  = cnt_inc;
      done_d = done_nxt_o;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/conv_mdc_stream_ctrl.sv
// Job sequencer gating N_IN streamer->kernel and N_OUT kernel->streamer channels to per-job beat lengths.
// Latency: zero on the data path; done_o pulses the cycle after the last channel's final beat.
// Backpressure: per-channel ready/valid pass straight through while the job runs; all gated to 0 outside RUN or once a channel is full.
module conv_mdc_stream_ctrl
  import conv_mdc_package::*;
#(
  parameter int unsigned N_IN       = 2,
  parameter int unsigned N_OUT      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [N_IN*CNT_WIDTH-1:0]   len_in_i,
  input  logic [N_OUT*CNT_WIDTH-1:0]  len_out_i,
  input  logic [N_IN-1:0]             src_valid_i,
  input  logic [N_IN*DATA_WIDTH-1:0]  src_data_i,
  output logic [N_IN-1:0]             src_ready_o,
  output logic [N_IN-1:0]             krn_valid_o,
  output logic [N_IN*DATA_WIDTH-1:0]  krn_data_o,
  input  logic [N_IN-1:0]             krn_ready_i,
  input  logic [N_OUT-1:0]            res_valid_i,
  input  logic [N_OUT*DATA_WIDTH-1:0] res_data_i,
  output logic [N_OUT-1:0]            res_ready_o,
  output logic [N_OUT-1:0]            dst_valid_o,
  output logic [N_OUT*DATA_WIDTH-1:0] dst_data_o,
  input  logic [N_OUT-1:0]            dst_ready_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [N_IN+N_OUT-1:0]       ch_done_o
);

  localparam int unsigned N_CH = N_IN + N_OUT;

  fsm_state_e      state_q, state_d;
  logic            run;
  logic            load;
  logic [N_CH-1:0] ch_done;
  logic [N_CH-1:0] ch_done_nxt;

  // Next-state: leave RUN on the same edge the last channel completes, so done_o follows the final beat by one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (&ch_done_nxt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Per-state controls to the channel gates; start is only honoured in IDLE.
  always_comb begin
    run    = (state_q == RUN);
    load   = (state_q == IDLE) & start_i & ~clear_i;
    busy_o = run;
    done_o = (state_q == DONE);
  end

  assign ch_done_o = ch_done;

  for (genvar c = 0; c < N_IN; c++) begin : g_in
    conv_mdc_stream_gate #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_gate (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .load_i     (load),
      .run_i      (run),
      .len_i      (len_in_i[c*CNT_WIDTH +: CNT_WIDTH]),
      .up_valid_i (src_valid_i[c]),
      .up_data_i  (src_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .up_ready_o (src_ready_o[c]),
      .dn_valid_o (krn_valid_o[c]),
      .dn_data_o  (krn_data_o[c*DATA_WIDTH +: DATA_WIDTH]),
      .dn_ready_i (krn_ready_i[c]),
      .done_o     (ch_done[c]),
      .done_nxt_o (ch_done_nxt[c])
    );
  end

  for (genvar c = 0; c < N_OUT; c++) begin : g_out
    conv_mdc_stream_gate #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_gate (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .load_i     (load),
      .run_i      (run),
      .len_i      (len_out_i[c*CNT_WIDTH +: CNT_WIDTH]),
      .up_valid_i (res_valid_i[c]),
      .up_data_i  (res_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .up_ready_o (res_ready_o[c]),
      .dn_valid_o (dst_valid_o[c]),
      .dn_data_o  (dst_data_o[c*DATA_WIDTH +: DATA_WIDTH]),
      .dn_ready_i (dst_ready_i[c]),
      .done_o     (ch_done[N_IN+c]),
      .done_nxt_o (ch_done_nxt[N_IN+c])
    );
  end

endmodule

// File: tb/tb_conv_mdc_stream_ctrl.sv
// Directed bench for conv_mdc_stream_ctrl with two input channels and one output channel.
// Latency: n/a.
// Backpressure: stimulus drives both continuous and random valid/ready patterns.
module tb_conv_mdc_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        start;
  logic [31:0] len_in;
  logic [15:0] len_out;
  logic [1:0]  src_valid;
  logic [63:0] src_data;
  logic [1:0]  src_ready;
  logic [1:0]  krn_valid;
  logic [63:0] krn_data;
  logic [1:0]  krn_ready;
  logic [0:0]  res_valid;
  logic [31:0] res_data;
  logic [0:0]  res_ready;
  logic [0:0]  dst_valid;
  logic [31:0] dst_data;
  logic [0:0]  dst_ready;
  logic        busy;
  logic        done;
  logic [2:0]  ch_done;

  always #5 clk = ~clk;

  conv_mdc_stream_ctrl #(
    .N_IN(2), .N_OUT(1), .DATA_WIDTH(32), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .len_in_i(len_in), .len_out_i(len_out),
    .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(src_ready),
    .krn_valid_o(krn_valid), .krn_data_o(krn_data), .krn_ready_i(krn_ready),
    .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
    .dst_valid_o(dst_valid), .dst_data_o(dst_data), .dst_ready_i(dst_ready),
    .busy_o(busy), .done_o(done), .ch_done_o(ch_done)
  );

  // Beat monitor: source-side counters drive the payload, sink-side queues record what arrived.
  logic        mon_clr = 1'b0;
  int          src_cnt0 = 0, src_cnt1 = 0, res_cnt = 0;
  logic [31:0] krn_q0[$], krn_q1[$], dst_q[$];

  assign src_data = {32'hB000_0000 + 32'(src_cnt1), 32'hA000_0000 + 32'(src_cnt0)};
  assign res_data = 32'hC000_0000 + 32'(res_cnt);

  always @(posedge clk) begin
    if (mon_clr) begin
      src_cnt0 <= 0; src_cnt1 <= 0; res_cnt <= 0;
      krn_q0.delete(); krn_q1.delete(); dst_q.delete();
    end else begin
      if (src_valid[0] && src_ready[0]) src_cnt0 <= src_cnt0 + 1;
      if (src_valid[1] && src_ready[1]) src_cnt1 <= src_cnt1 + 1;
      if (res_valid[0] && res_ready[0]) res_cnt <= res_cnt + 1;
      if (krn_valid[0] && krn_ready[0]) krn_q0.push_back(krn_data[31:0]);
      if (krn_valid[1] && krn_ready[1]) krn_q1.push_back(krn_data[63:32]);
      if (dst_valid[0] && dst_ready[0]) dst_q.push_back(dst_data);
    end
  end

  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic all_on();
    src_valid = 2'b11; krn_ready = 2'b11; res_valid = 1'b1; dst_ready = 1'b1;
  endtask

  // Launches a job from IDLE and observes ncyc cycles starting with the first RUN cycle.
  task automatic run_job(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] lo,
                         input int ncyc, input bit rnd, input int snap_i,
                         output int busy_n, output int done_n, output int done_at,
                         output logic [1:0] snap_rdy, output logic [2:0] snap_chd);
    len_in = {l1, l0}; len_out = lo; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; snap_rdy = 2'bxx; snap_chd = 3'bxxx;
    for (int i = 0; i < ncyc; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (i == snap_i) begin
        snap_rdy = src_ready;
        snap_chd = ch_done;
      end
      if (rnd) begin
        src_valid = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
        krn_ready = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
        res_valid = ($urandom_range(3) != 0);
        dst_ready = ($urandom_range(3) != 0);
      end
      @(negedge clk);
    end
  endtask

  int         b_n, d_n, d_at, derr, cnt;
  logic [1:0] s_rdy;
  logic [2:0] s_chd;

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; len_in = '0; len_out = '0;
    all_on();

    // Reset state: everything gated, data passes through.
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ch_done", ch_done, 3'b000);
    chk("rst_src_ready", src_ready, 2'b00);
    chk("rst_krn_valid", krn_valid, 2'b00);
    chk("rst_res_ready", res_ready, 1'b0);
    chk("rst_dst_valid", dst_valid, 1'b0);
    chk("rst_krn_data", krn_data, 64'hB000_0000_A000_0000);
    @(negedge clk);
    rst = 1'b0;
    clr_mon();

    // Job 4/4 in, 2 out, always ready.
    run_job(16'd4, 16'd4, 16'd2, 8, 1'b0, 0, b_n, d_n, d_at, s_rdy, s_chd);
    chk("j1_busy_cycles", b_n, 4);
    chk("j1_done_count", d_n, 1);
    chk("j1_done_at", d_at, 4);
    chk("j1_first_rdy", s_rdy, 2'b11);
    chk("j1_first_chd", s_chd, 3'b000);
    chk("j1_krn0_beats", krn_q0.size(), 4);
    chk("j1_krn1_beats", krn_q1.size(), 4);
    chk("j1_dst_beats", dst_q.size(), 2);
    chk("j1_chd_hold", ch_done, 3'b111);
    chk("j1_idle_rdy", src_ready, 2'b00);
    clr_mon();

    // Job 3/5 in, 2 out: ch0 closes while ch1 keeps going.
    run_job(16'd3, 16'd5, 16'd2, 9, 1'b0, 3, b_n, d_n, d_at, s_rdy, s_chd);
    chk("j2_busy_cycles", b_n, 5);
    chk("j2_done_at", d_at, 5);
    chk("j2_mid_rdy", s_rdy, 2'b10);
    chk("j2_mid_chd", s_chd, 3'b101);
    chk("j2_krn0_beats", krn_q0.size(), 3);
    chk("j2_krn1_beats", krn_q1.size(), 5);
    chk("j2_src0_beats", src_cnt0, 3);
    clr_mon();

    // All lengths zero: one RUN cycle, no handshakes.
    run_job(16'd0, 16'd0, 16'd0, 5, 1'b0, 0, b_n, d_n, d_at, s_rdy, s_chd);
    chk("j3_busy_cycles", b_n, 1);
    chk("j3_done_at", d_at, 1);
    chk("j3_done_count", d_n, 1);
    chk("j3_first_rdy", s_rdy, 2'b00);
    chk("j3_beats", krn_q0.size() + krn_q1.size() + dst_q.size(), 0);
    chk("j3_chd", ch_done, 3'b111);
    clr_mon();

    // Random backpressure, 100 beats per channel, in-order data.
    run_job(16'd100, 16'd100, 16'd100, 1000, 1'b1, 0, b_n, d_n, d_at, s_rdy, s_chd);
    all_on();
    chk("j4_done_count", d_n, 1);
    chk("j4_krn0_beats", krn_q0.size(), 100);
    chk("j4_krn1_beats", krn_q1.size(), 100);
    chk("j4_dst_beats", dst_q.size(), 100);
    derr = 0;
    foreach (krn_q0[k]) if (krn_q0[k] !== 32'hA000_0000 + 32'(k)) derr++;
    foreach (krn_q1[k]) if (krn_q1[k] !== 32'hB000_0000 + 32'(k)) derr++;
    foreach (dst_q[k])  if (dst_q[k]  !== 32'hC000_0000 + 32'(k)) derr++;
    chk("j4_data_errors", derr, 0);
    clr_mon();

    // Clear after 7 of 10 beats, then a fresh 10-beat job.
    len_in = {16'd10, 16'd10}; len_out = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && krn_q0.size() != 7; i++) @(negedge clk);
    chk("j5_pre_clear_beats", krn_q0.size(), 7);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("j5_busy", busy, 0);
    chk("j5_chd", ch_done, 3'b000);
    chk("j5_src_ready", src_ready, 2'b00);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("j5_no_done", cnt, 0);
    clr_mon();
    run_job(16'd10, 16'd10, 16'd10, 14, 1'b0, 0, b_n, d_n, d_at, s_rdy, s_chd);
    chk("j5_busy_cycles", b_n, 10);
    chk("j5_done_at", d_at, 10);
    chk("j5_krn0_beats", krn_q0.size(), 10);
    chk("j5_dst_beats", dst_q.size(), 10);
    clr_mon();

    // start_i during RUN with different lengths is ignored.
    len_in = {16'd6, 16'd6}; len_out = 16'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; len_in = {16'd1, 16'd1}; len_out = 16'd1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("j6_done_count", cnt, 1);
    chk("j6_krn0_beats", krn_q0.size(), 6);
    chk("j6_krn1_beats", krn_q1.size(), 6);
    chk("j6_dst_beats", dst_q.size(), 6);
    clr_mon();

    // Asynchronous reset mid-job.
    len_in = {16'd6, 16'd6}; len_out = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("j7_busy_pre", busy, 1);
    chk("j7_chd_pre", ch_done, 3'b100);
    #2 rst = 1'b1;
    #1;
    chk("j7_busy_rst", busy, 0);
    chk("j7_chd_rst", ch_done, 3'b000);
    chk("j7_src_ready_rst", src_ready, 2'b00);
    chk("j7_krn_valid_rst", krn_valid, 2'b00);
    chk("j7_dst_valid_rst", dst_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("j7_idle_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
